// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: frame sequencer for the UART receive path.
// Detects the start bit, runs the oversampling edge counter and the data bit
// counter, and enables the sampler, deserializer and start/parity/stop
// checkers in turn. Each frame ends with a one-cycle data_valid or frame_err.
// Optional feature macro: UART_RX_ERR_CNT_EN adds err_cnt and last_err.

module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            RX_IN,
  input  logic                            PAR_EN,
  input  logic [5:0]                      prescale,
  input  logic                            strt_glitch,
  input  logic                            par_err,
  input  logic                            stp_err,
  output logic [5:0]                      edge_cnt,
  output logic [$clog2(DATA_WIDTH+1)-1:0] bit_cnt,
  output logic                            samp_en,
  output logic                            deser_en,
  output logic                            strt_chk_en,
  output logic                            par_chk_en,
  output logic                            stp_chk_en,
  output logic                            data_valid,
  output logic                            frame_err,
`ifdef UART_RX_ERR_CNT_EN
  output logic [7:0]                      err_cnt,
  output logic [1:0]                      last_err,
`endif
  output logic                            busy
);

  localparam int BW = $clog2(DATA_WIDTH+1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       pe_q;
  logic [5:0] ps_q;
  logic       err_q;
  logic       bit_end;
  logic       dv_next;
  logic       fe_next;

  // Last oversampling edge of the current bit; only meaningful outside IDLE.
  assign bit_end = (edge_cnt == (ps_q - 6'd1));

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state, end-of-frame pulse decisions and Moore enables.
  always_comb begin
    state_next  = state;
    dv_next     = 1'b0;
    fe_next     = 1'b0;
    busy        = 1'b1;
    deser_en    = 1'b0;
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (!RX_IN) state_next = START;
      end
      START: begin
        strt_chk_en = 1'b1;
        if (bit_end) begin
          if (strt_glitch) begin
            state_next = IDLE;
            fe_next    = 1'b1;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        deser_en = 1'b1;
        if (bit_end && (bit_cnt == BW'(DATA_WIDTH-1)))
          state_next = pe_q ? PARITY : STOP;
      end
      PARITY: begin
        par_chk_en = 1'b1;
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        stp_chk_en = 1'b1;
        if (bit_end) begin
          state_next = IDLE;
          if (err_q | stp_err) fe_next = 1'b1;
          else                 dv_next = 1'b1;
        end
      end
      default: begin
        busy       = 1'b0;
        state_next = IDLE;
      end
    endcase
    samp_en = busy;
  end

  // Config capture at start detect, edge/bit counters and the parity error latch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
      pe_q     <= 1'b0;
      ps_q     <= 6'd8;
      err_q    <= 1'b0;
    end else if (state == IDLE) begin
      edge_cnt <= '0;
      if (!RX_IN) begin
        pe_q    <= PAR_EN;
        ps_q    <= (prescale < 6'd4) ? 6'd8 : prescale;
        bit_cnt <= '0;
        err_q   <= 1'b0;
      end
    end else begin
      edge_cnt <= bit_end ? 6'd0 : (edge_cnt + 6'd1);
      if ((state == DATA) && bit_end)   bit_cnt <= bit_cnt + BW'(1);
      if ((state == PARITY) && bit_end) err_q   <= par_err;
    end
  end

  // Registered one-cycle result pulses, aligned with the return to IDLE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= dv_next;
      frame_err  <= fe_next;
    end
  end

`ifdef UART_RX_ERR_CNT_EN
  // Saturating error counter and cause of the most recent frame error.
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_cnt  <= 8'd0;
      last_err <= 2'b00;
    end else if (fe_next) begin
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (state == START) last_err <= 2'b01;
      else if (err_q)     last_err <= 2'b10;
      else                last_err <= 2'b11;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: randomized self-checking bench for uart_rx_ctrl.
// Expected outputs come from frame arithmetic: each frame is a list of bits
// (start, data, optional parity, stop) each lasting ps cycles.

module tb_uart_rx_ctrl;

  localparam int DW = 8;
  localparam int BW = $clog2(DW+1);

  logic          CLK = 1'b0;
  logic          RST;
  logic          RX_IN;
  logic          PAR_EN;
  logic [5:0]    prescale;
  logic          strt_glitch;
  logic          par_err;
  logic          stp_err;
  logic [5:0]    edge_cnt;
  logic [BW-1:0] bit_cnt;
  logic          samp_en;
  logic          deser_en;
  logic          strt_chk_en;
  logic          par_chk_en;
  logic          stp_chk_en;
  logic          data_valid;
  logic          frame_err;
  logic          busy;
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0]    err_cnt;
  logic [1:0]    last_err;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int model_err_cnt = 0;
  int model_last_err = 0;
  int model_bit_cnt = 0;

  uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .PAR_EN      (PAR_EN),
    .prescale    (prescale),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .samp_en     (samp_en),
    .deser_en    (deser_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .data_valid  (data_valid),
    .frame_err   (frame_err),
`ifdef UART_RX_ERR_CNT_EN
    .err_cnt     (err_cnt),
    .last_err    (last_err),
`endif
    .busy        (busy)
  );

  always #5 CLK = ~CLK;

  // Safety net in case the bench itself stalls.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  function automatic logic [5:0] pickPrescale();
    int sel;
    sel = $urandom_range(0, 6);
    case (sel)
      0: return 6'd0;
      1: return 6'd3;
      2: return 6'd16;
      3: return 6'd32;
      default: return 6'd8;
    endcase
  endfunction

  function automatic logic [5:0] enables();
    return {samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, busy};
  endfunction

  task automatic randomizeInputs();
    strt_glitch = 1'($urandom);
    par_err     = 1'($urandom);
    stp_err     = 1'($urandom);
  endtask

  task automatic checkCounters();
`ifdef UART_RX_ERR_CNT_EN
    checkOutput("err_cnt", 32'(err_cnt), 32'(model_err_cnt));
    checkOutput("last_err", 32'(last_err), 32'(model_last_err));
`endif
  endtask

  // Quiet line cycles: controller must sit in IDLE with no pulses.
  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      RX_IN    = 1'b1;
      PAR_EN   = 1'($urandom);
      prescale = pickPrescale();
      randomizeInputs();
      @(negedge CLK);
      checkOutput("idle_edge_cnt", 32'(edge_cnt), 32'd0);
      checkOutput("idle_bit_cnt", 32'(bit_cnt), 32'(model_bit_cnt));
      checkOutput("idle_enables", 32'(enables()), 32'd0);
      checkOutput("idle_pulses", 32'({data_valid, frame_err}), 32'd0);
      checkCounters();
    end
  endtask

  // Drive one frame from the current (IDLE) cycle, checking every cycle.
  // abort_k > 0 asserts RST in frame cycle abort_k.
  task automatic applyStimulus(input logic [5:0] ps_raw, input logic pe,
                               input logic glitch, input logic perr,
                               input logic serr, input int abort_k);
    int ps, n_bits, len, phase, edge_i, exp_bc;
    logic exp_fe;
    logic [5:0] exp_en;
    ps     = (ps_raw < 6'd4) ? 8 : int'(ps_raw);
    n_bits = glitch ? 1 : (2 + DW + int'(pe));
    len    = ps * n_bits + 1;
    exp_fe = glitch | (pe & perr) | serr;
    RX_IN    = 1'b0;
    PAR_EN   = pe;
    prescale = ps_raw;
    randomizeInputs();
    for (int k = 1; k <= len; k++) begin
      @(negedge CLK);
      if (k == len) begin
        model_bit_cnt = glitch ? 0 : DW;
        if (exp_fe) begin
          if (model_err_cnt < 255) model_err_cnt++;
          model_last_err = glitch ? 1 : ((pe & perr) ? 2 : 3);
        end
        checkOutput("end_edge_cnt", 32'(edge_cnt), 32'd0);
        checkOutput("end_bit_cnt", 32'(bit_cnt), 32'(model_bit_cnt));
        checkOutput("end_enables", 32'(enables()), 32'd0);
        checkOutput("end_data_valid", 32'(data_valid), 32'(!exp_fe));
        checkOutput("end_frame_err", 32'(frame_err), 32'(exp_fe));
        checkCounters();
        RX_IN = 1'b1;
        randomizeInputs();
        return;
      end
      phase  = (k - 1) / ps;
      edge_i = (k - 1) % ps;
      if (phase == 0)                 begin exp_en = 6'b101001; exp_bc = 0; end
      else if (phase <= DW)           begin exp_en = 6'b110001; exp_bc = phase - 1; end
      else if (pe && phase == DW + 1) begin exp_en = 6'b100101; exp_bc = DW; end
      else                            begin exp_en = 6'b100011; exp_bc = DW; end
      checkOutput("edge_cnt", 32'(edge_cnt), 32'(edge_i));
      checkOutput("bit_cnt", 32'(bit_cnt), 32'(exp_bc));
      checkOutput("enables", 32'(enables()), 32'(exp_en));
      checkOutput("mid_pulses", 32'({data_valid, frame_err}), 32'd0);
      if (k == abort_k) begin
        RST   = 1'b1;
        RX_IN = 1'b1;
        @(negedge CLK);
        model_err_cnt  = 0;
        model_last_err = 0;
        model_bit_cnt  = 0;
        checkOutput("abort_edge_cnt", 32'(edge_cnt), 32'd0);
        checkOutput("abort_bit_cnt", 32'(bit_cnt), 32'd0);
        checkOutput("abort_enables", 32'(enables()), 32'd0);
        checkOutput("abort_pulses", 32'({data_valid, frame_err}), 32'd0);
        checkCounters();
        RST = 1'b0;
        return;
      end
      RX_IN    = 1'($urandom);
      PAR_EN   = 1'($urandom);
      prescale = pickPrescale();
      randomizeInputs();
      if (edge_i == ps - 1) begin
        if (phase == 0) strt_glitch = glitch;
        if (!glitch && pe && phase == DW + 1) par_err = perr;
        if (!glitch && phase == n_bits - 1)   stp_err = serr;
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    RX_IN = 1'b1;
    PAR_EN = 1'b0;
    prescale = 6'd8;
    strt_glitch = 1'b0;
    par_err = 1'b0;
    stp_err = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("rst_edge_cnt", 32'(edge_cnt), 32'd0);
    checkOutput("rst_bit_cnt", 32'(bit_cnt), 32'd0);
    checkOutput("rst_enables", 32'(enables()), 32'd0);
    checkOutput("rst_pulses", 32'({data_valid, frame_err}), 32'd0);
    checkCounters();
    RST = 1'b0;
    idleCycles(2);

    // Clean parity frame, no-parity frame, start glitch, parity error.
    applyStimulus(6'd8, 1'b1, 1'b0, 1'b0, 1'b0, 0);  idleCycles(2);
    applyStimulus(6'd16, 1'b0, 1'b0, 1'b0, 1'b0, 0); idleCycles(2);
    applyStimulus(6'd8, 1'b1, 1'b1, 1'b0, 1'b0, 0);  idleCycles(2);
    applyStimulus(6'd8, 1'b1, 1'b0, 1'b1, 1'b0, 0);  idleCycles(2);
    applyStimulus(6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0);  idleCycles(1);
    applyStimulus(6'd8, 1'b1, 1'b0, 1'b1, 1'b1, 0);  idleCycles(1);

    // Reset at edge 3 of the bit where bit_cnt is 4, then a clean frame.
    applyStimulus(6'd8, 1'b1, 1'b0, 1'b0, 1'b0, 5 * 8 + 3 + 1);
    idleCycles(2);
    applyStimulus(6'd8, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // Back-to-back frames at prescale 32 starting on the pulse cycle.
    applyStimulus(6'd32, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(6'd32, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    idleCycles(1);

    // Randomized frames, optionally back-to-back.
    for (int f = 0; f < 25; f++) begin
      applyStimulus(pickPrescale(), 1'($urandom), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), 0);
      if ($urandom_range(0, 1) == 0) idleCycles($urandom_range(1, 3));
    end

`ifdef UART_RX_ERR_CNT_EN
    // Drive the error counter into saturation with short glitch frames.
    for (int f = 0; f < 260; f++)
      applyStimulus(6'd8, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    idleCycles(1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Frame-sequencing controller for the UART receive path. It detects the start bit and owns the per-bit edge counter and the bit counter. It drives the sampler, deserializer and start/parity/stop checker enables through the frame. It collects checker results and issues a single-cycle data_valid or frame_err per frame.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (4..15)

Ports:
CLK  in  1  system clock (UART RX clock domain)
RST  in  1  reset
RX_IN  in  1  serial line, idle high
PAR_EN  in  1  parity bit present in frame
prescale  in  6  oversampling ratio; 8, 16 and 32 are supported
strt_glitch  in  1  start-check result, valid while strt_chk_en=1
par_err  in  1  parity-check result, valid while par_chk_en=1
stp_err  in  1  stop-check result, valid while stp_chk_en=1
edge_cnt  out  6  oversampling edge index within current bit
bit_cnt  out  $clog2(DATA_WIDTH+1)  data bits completed
samp_en  out  1  sampler enable
deser_en  out  1  deserializer enable
strt_chk_en  out  1  start checker enable
par_chk_en  out  1  parity checker enable
stp_chk_en  out  1  stop checker enable
data_valid  out  1  one-cycle pulse: frame received without error
frame_err  out  1  one-cycle pulse: frame aborted or errored
busy  out  1  high in any state other than IDLE

Behaviour:
- One clock; reset is synchronous and active-high. RST=1 at a CLK edge forces the following, regardless of state (including mid-frame): IDLE, edge_cnt=0, bit_cnt=0, all enables/pulses/busy=0, error latch cleared.
- Config capture: in IDLE, on RX_IN=0 register PAR_EN→pe_q and prescale→ps_q. A prescale value <4 is stored as 8. Config changes mid-frame are ignored.
- edge_cnt: 0 in IDLE. In any other state it increments each cycle and wraps to 0 after ps_q-1. "Bit end" means edge_cnt==ps_q-1.
- All enables are decoded from the state register only (Moore). samp_en=busy.
- States/transitions:
  - IDLE: RX_IN=0 → START next cycle, edge_cnt=0.
  - START: strt_chk_en=1. At bit end, if strt_glitch=1 → IDLE with frame_err pulse. Otherwise → DATA with bit_cnt=0.
  - DATA: deser_en=1. At bit end bit_cnt increments. When bit_cnt reaches DATA_WIDTH → PARITY if pe_q, else STOP. bit_cnt holds DATA_WIDTH until the next frame start.
  - PARITY: par_chk_en=1. At bit end, latch err_q=par_err, then → STOP.
  - STOP: stp_chk_en=1. At bit end → IDLE. If (err_q|stp_err) pulse frame_err, else pulse data_valid.
- data_valid/frame_err are registered: asserted the cycle state enters IDLE, for exactly one cycle, and mutually exclusive.
- Frame length from the start-detect cycle to the pulse = ps_q×(2+DATA_WIDTH+pe_q)+1 cycles.
- Back-to-back frames: RX_IN=0 seen in IDLE on the pulse cycle starts the next frame immediately. No idle cycle is required beyond one.
- RX_IN sampled in START/DATA/PARITY/STOP is ignored by this block (checkers own the line).
- Checker inputs are only used on the bit-end cycle of their own state. Other values are don't-care.

Optional Feature:
UART_RX_ERR_CNT_EN
- Defined: adds output err_cnt[7:0]. It increments on every frame_err pulse, saturates at 255, and is cleared only by RST. It also adds output last_err[1:0]: 01=start glitch, 10=parity, 11=stop. It is updated with frame_err; parity takes priority over stop when both occur.
- Not defined: the ports and logic are absent. All other behaviour is identical.

Test Plan:
- prescale=8, PAR_EN=1, clean frame 0xA5 with even-parity checker reporting no error → data_valid high exactly 89 cycles after start-detect, bit_cnt=8, frame_err never high.
- prescale=16, PAR_EN=0 → PARITY never entered, par_chk_en stays 0, data_valid 161 cycles after start-detect.
- prescale=8, strt_glitch=1 at start bit end → frame_err pulse at cycle 9, deser_en never asserted, IDLE.
- prescale=8, PAR_EN=1, par_err=1 at parity bit end, stp_err=0 → STOP still executed, frame_err at cycle 89, data_valid=0. With UART_RX_ERR_CNT_EN: err_cnt=1, last_err=10.
- RST=1 asserted at edge_cnt=3 of data bit 4 → next cycle IDLE, all outputs 0; the next clean frame is received normally.
- Two back-to-back frames, prescale=32, RX_IN falling on the first frame's pulse cycle → two data_valid pulses 353 cycles apart; prescale changed to 8 mid-frame has no effect on the current frame.
